// File: rtl/surf_cout_tx_framer.sv
// surf_cout_tx_framer: SURF-side COUT/DOUT transmit framer (sysclk domain).
// COUT carries framed 32-bit response words as nibbles; DOUT carries fixed-length
// byte packets. Both channels send bitslip training patterns while train_i is high.
// Optional feature macro: SURF_COUT_TX_PARITY_EN adds a trailing XOR-parity nibble
// to every COUT frame.
module surf_cout_tx_framer #(
    parameter int DOUT_LEN = 16
) (
    input  logic        sysclk_i,
    input  logic        rst_n_i,
    input  logic        train_i,
    input  logic [31:0] resp_dat_i,
    input  logic        resp_valid_i,
    output logic        resp_ready_o,
    input  logic [7:0]  dout_dat_i,
    input  logic        dout_valid_i,
    output logic        dout_ready_o,
    output logic [3:0]  cout_o,
    output logic [7:0]  dout_o,
    output logic        err_underflow_o
);

    localparam logic [3:0] COUT_TRAIN = 4'h6;
    localparam logic [3:0] COUT_START = 4'h8;
    localparam logic [7:0] DOUT_TRAIN = 8'h6A;
    localparam logic [7:0] DOUT_SOF   = 8'hBC;
    localparam logic [7:0] DOUT_LEN8  = 8'(DOUT_LEN);

`ifdef SURF_COUT_TX_PARITY_EN
    typedef enum logic [2:0] {C_TRAIN, C_IDLE, C_START, C_DATA, C_PAR} cstate_t;
`else
    typedef enum logic [2:0] {C_TRAIN, C_IDLE, C_START, C_DATA} cstate_t;
`endif
    typedef enum logic [1:0] {D_TRAIN, D_IDLE, D_SOF, D_DATA} dstate_t;

    cstate_t     cst_q, cst_d;
    dstate_t     dst_q, dst_d;
    logic [3:0]  cout_q, cout_d;
    logic [3:0]  nib_q, nib_d;       // number of data nibbles already on the wire
    logic [31:0] word_q, word_d;     // captured word, shifted left as nibbles go out
    logic [7:0]  dout_q, dout_d;
    logic [7:0]  cnt_q, cnt_d;       // data bytes left including the one on the wire
    logic        err_q, err_d;
`ifdef SURF_COUT_TX_PARITY_EN
    logic [3:0]  par_q, par_d;       // running XOR of the nibbles sent so far
`endif

    assign resp_ready_o    = (cst_q == C_IDLE) && !train_i;
    assign dout_ready_o    = (dst_q == D_SOF) || ((dst_q == D_DATA) && (cnt_q > 8'd1));
    assign cout_o          = cout_q;
    assign dout_o          = dout_q;
    assign err_underflow_o = err_q;

    // COUT next state: the state register always names the nibble currently on cout_o
    always_comb begin
        cst_d  = cst_q;
        cout_d = cout_q;
        nib_d  = nib_q;
        word_d = word_q;
`ifdef SURF_COUT_TX_PARITY_EN
        par_d  = par_q;
`endif
        case (cst_q)
            C_TRAIN: begin
                if (!train_i) begin
                    cst_d  = C_IDLE;
                    cout_d = 4'h0;
                end else begin
                    cout_d = COUT_TRAIN;
                end
            end
            C_IDLE: begin
                if (train_i) begin
                    cst_d  = C_TRAIN;
                    cout_d = COUT_TRAIN;
                end else if (resp_valid_i) begin
                    cst_d  = C_START;
                    cout_d = COUT_START;
                    word_d = resp_dat_i;
`ifdef SURF_COUT_TX_PARITY_EN
                    par_d  = 4'h0;
`endif
                end else begin
                    cout_d = 4'h0;
                end
            end
            C_START: begin
                cst_d  = C_DATA;
                cout_d = word_q[31:28];
                word_d = {word_q[27:0], 4'h0};
                nib_d  = 4'd1;
`ifdef SURF_COUT_TX_PARITY_EN
                par_d  = par_q ^ word_q[31:28];
`endif
            end
            C_DATA: begin
                if (nib_q == 4'd8) begin
`ifdef SURF_COUT_TX_PARITY_EN
                    cst_d  = C_PAR;
                    cout_d = par_q;
`else
                    cst_d  = C_IDLE;
                    cout_d = 4'h0;
`endif
                end else begin
                    cout_d = word_q[31:28];
                    word_d = {word_q[27:0], 4'h0};
                    nib_d  = nib_q + 4'd1;
`ifdef SURF_COUT_TX_PARITY_EN
                    par_d  = par_q ^ word_q[31:28];
`endif
                end
            end
`ifdef SURF_COUT_TX_PARITY_EN
            C_PAR: begin
                cst_d  = C_IDLE;
                cout_d = 4'h0;
            end
`endif
            default: begin
                cst_d  = C_TRAIN;
                cout_d = COUT_TRAIN;
            end
        endcase
    end

    // DOUT next state: SOF loads the length; each data cycle places a byte or a 0x00 filler
    always_comb begin
        dst_d  = dst_q;
        dout_d = dout_q;
        cnt_d  = cnt_q;
        err_d  = err_q;
        case (dst_q)
            D_TRAIN: begin
                if (!train_i) begin
                    dst_d  = D_IDLE;
                    dout_d = 8'h00;
                end else begin
                    dout_d = DOUT_TRAIN;
                end
            end
            D_IDLE: begin
                if (train_i) begin
                    dst_d  = D_TRAIN;
                    dout_d = DOUT_TRAIN;
                    err_d  = 1'b0;
                end else if (dout_valid_i) begin
                    dst_d  = D_SOF;
                    dout_d = DOUT_SOF;
                end else begin
                    dout_d = 8'h00;
                end
            end
            D_SOF: begin
                dst_d  = D_DATA;
                cnt_d  = DOUT_LEN8;
                dout_d = dout_valid_i ? dout_dat_i : 8'h00;
                if (!dout_valid_i) err_d = 1'b1;
            end
            D_DATA: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    dst_d  = D_IDLE;
                    dout_d = 8'h00;
                end else begin
                    dout_d = dout_valid_i ? dout_dat_i : 8'h00;
                    if (!dout_valid_i) err_d = 1'b1;
                end
            end
            default: begin
                dst_d  = D_TRAIN;
                dout_d = DOUT_TRAIN;
            end
        endcase
    end

    // Control and output registers; reset forces training symbols immediately
    always_ff @(posedge sysclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cst_q  <= C_TRAIN;
            dst_q  <= D_TRAIN;
            cout_q <= COUT_TRAIN;
            dout_q <= DOUT_TRAIN;
            nib_q  <= 4'd0;
            cnt_q  <= 8'd0;
            err_q  <= 1'b0;
        end else begin
            cst_q  <= cst_d;
            dst_q  <= dst_d;
            cout_q <= cout_d;
            dout_q <= dout_d;
            nib_q  <= nib_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    // Payload registers need no reset: they are always loaded before being sent
    always_ff @(posedge sysclk_i) begin
        word_q <= word_d;
`ifdef SURF_COUT_TX_PARITY_EN
        par_q  <= par_d;
`endif
    end

endmodule

// File: tb/tb_surf_cout_tx_framer.sv
// Bench for surf_cout_tx_framer: randomized and directed stimulus compared every
// cycle against a symbol-queue reference model of both channels.
module tb_surf_cout_tx_framer;

    localparam int LEN = 4;
    localparam logic [7:0] PAT [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    logic        sysclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        train = 1'b1;
    logic [31:0] resp_dat = '0;
    logic        resp_valid = 1'b0;
    logic        resp_ready;
    logic [7:0]  dout_dat = '0;
    logic        dout_valid = 1'b0;
    logic        dout_ready;
    logic [3:0]  cout;
    logic [7:0]  dout;
    logic        err_uf;

    int checks = 0;
    int errors = 0;

    surf_cout_tx_framer #(.DOUT_LEN(LEN)) dut (
        .sysclk_i(sysclk), .rst_n_i(rst_n), .train_i(train),
        .resp_dat_i(resp_dat), .resp_valid_i(resp_valid), .resp_ready_o(resp_ready),
        .dout_dat_i(dout_dat), .dout_valid_i(dout_valid), .dout_ready_o(dout_ready),
        .cout_o(cout), .dout_o(dout), .err_underflow_o(err_uf)
    );

    always #5 sysclk = ~sysclk;

    // Reference model: mode 0 = training, 1 = idle, 2 = sending a frame/packet
    int         c_mode;
    logic [3:0] c_exp;
    logic [3:0] c_q[$];
    int         d_mode;
    int         d_need;       // data bytes still to be placed on the wire
    logic [7:0] d_exp;
    logic       err_exp;
    bit         d_hs;         // model saw a DOUT byte accepted at the last edge

    function automatic bit m_resp_ready();
        return (c_mode == 1) && !train;
    endfunction

    function automatic bit m_dout_ready();
        return (d_mode == 2) && (d_need > 0);
    endfunction

    function automatic void model_reset();
        c_mode = 0; c_exp = 4'h6; c_q.delete();
        d_mode = 0; d_need = 0; d_exp = 8'h6A; err_exp = 1'b0; d_hs = 1'b0;
    endfunction

    function automatic void model_step();
        logic [3:0] p;
        bit dr;
        if (!rst_n) begin
            model_reset();
            return;
        end
        dr   = m_dout_ready();
        d_hs = dr && dout_valid;
        // COUT
        case (c_mode)
            0: if (!train) begin c_mode = 1; c_exp = 4'h0; end else c_exp = 4'h6;
            1: begin
                if (train) begin
                    c_mode = 0; c_exp = 4'h6;
                end else if (resp_valid) begin
                    c_mode = 2; c_exp = 4'h8; p = 4'h0;
                    for (int i = 7; i >= 0; i--) begin
                        c_q.push_back(resp_dat[4*i +: 4]);
                        p = p ^ resp_dat[4*i +: 4];
                    end
`ifdef SURF_COUT_TX_PARITY_EN
                    c_q.push_back(p);
`endif
                end else c_exp = 4'h0;
            end
            default: begin
                if (c_q.size() > 0) c_exp = c_q.pop_front();
                else begin c_mode = 1; c_exp = 4'h0; end
            end
        endcase
        // DOUT
        case (d_mode)
            0: begin
                err_exp = 1'b0;
                if (!train) begin d_mode = 1; d_exp = 8'h00; end else d_exp = 8'h6A;
            end
            1: begin
                if (train) begin d_mode = 0; d_exp = 8'h6A; err_exp = 1'b0; end
                else if (dout_valid) begin d_mode = 2; d_exp = 8'hBC; d_need = LEN; end
                else d_exp = 8'h00;
            end
            default: begin
                if (d_need > 0) begin
                    d_exp = dout_valid ? dout_dat : 8'h00;
                    if (!dout_valid) err_exp = 1'b1;
                    d_need--;
                end else begin
                    d_mode = 1; d_exp = 8'h00;
                end
            end
        endcase
    endfunction

    // One cycle: compare outputs mid-cycle, then advance the model at the edge
    task automatic tick();
        @(negedge sysclk);
        checks += 5;
        if (cout !== c_exp) begin
            errors++; $display("FAIL cout: got %h expected %h at %0t", cout, c_exp, $time);
        end
        if (dout !== d_exp) begin
            errors++; $display("FAIL dout: got %h expected %h at %0t", dout, d_exp, $time);
        end
        if (err_uf !== err_exp) begin
            errors++; $display("FAIL err_underflow: got %b expected %b at %0t", err_uf, err_exp, $time);
        end
        if (resp_ready !== m_resp_ready()) begin
            errors++; $display("FAIL resp_ready: got %b expected %b at %0t", resp_ready, m_resp_ready(), $time);
        end
        if (dout_ready !== m_dout_ready()) begin
            errors++; $display("FAIL dout_ready: got %b expected %b at %0t", dout_ready, m_dout_ready(), $time);
        end
        @(posedge sysclk);
        model_step();
        #1;
    endtask

    task automatic go_idle(input int n);
        train = 1'b0; resp_valid = 1'b0; dout_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; train = 1'b1;
        model_reset();
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (20) tick();
        train = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_cout_stream();
        go_idle(12);
        resp_dat = 32'h1234ABCD; resp_valid = 1'b1;
        repeat (35) tick();
        resp_valid = 1'b0;
        repeat (12) tick();
    endtask

    task automatic test_dout_stream();
        int idx = 0;
        go_idle(12);
        for (int k = 0; k < 30; k++) begin
            dout_dat = PAT[idx % 4]; dout_valid = 1'b1;
            tick();
            if (d_hs) idx++;
        end
        dout_valid = 1'b0;
        repeat (8) tick();
    endtask

    task automatic test_underflow();
        int  acc = 0;
        bit  dropped = 0;
        go_idle(8);
        for (int k = 0; k < 12; k++) begin
            dout_valid = !(acc == 2 && !dropped);
            if (acc == 2 && !dropped) dropped = 1;
            dout_dat = PAT[acc % 4];
            tick();
            if (d_hs) acc++;
        end
        dout_valid = 1'b0;
        repeat (5) tick();
        checks++;
        if (err_uf !== 1'b1) begin
            errors++; $display("FAIL underflow_sticky: got %b expected 1", err_uf);
        end
        train = 1'b1;
        repeat (4) tick();
        train = 1'b0;
        repeat (3) tick();
        checks++;
        if (err_uf !== 1'b0) begin
            errors++; $display("FAIL underflow_clear: got %b expected 0", err_uf);
        end
    endtask

    task automatic test_train_mid_frame();
        go_idle(12);
        resp_dat = $urandom; resp_valid = 1'b1;
        repeat (4) tick();        // third data nibble now on the wire
        train = 1'b1;
        repeat (16) tick();
        resp_valid = 1'b0;
        train = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_async_reset();
        int guard = 0;
        go_idle(8);
        dout_dat = $urandom; dout_valid = 1'b1;
        while (!(d_mode == 2 && d_exp == 8'hBC) && guard < 20) begin
            tick(); guard++;
        end
        checks++;
        if (guard >= 20) begin
            errors++; $display("FAIL async_reset_setup: no SOF within %0d cycles", guard);
        end
        dout_valid = 1'b0; tick();       // starve the first data slot
        dout_valid = 1'b1; tick();
        #2 rst_n = 1'b0;
        #1;
        checks += 4;
        if (cout !== 4'h6) begin errors++; $display("FAIL async_cout: got %h expected 6", cout); end
        if (dout !== 8'h6A) begin errors++; $display("FAIL async_dout: got %h expected 6a", dout); end
        if (err_uf !== 1'b0) begin errors++; $display("FAIL async_err: got %b expected 0", err_uf); end
        if ({resp_ready, dout_ready} !== 2'b00) begin
            errors++; $display("FAIL async_ready: got %b expected 00", {resp_ready, dout_ready});
        end
        @(posedge sysclk);
        model_reset();
        #1;
        train = 1'b1;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        train = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_random();
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(59) == 0) train = !train;
            resp_valid = ($urandom_range(1) == 1);
            resp_dat   = $urandom;
            dout_valid = ($urandom_range(9) < 8);
            dout_dat   = 8'($urandom);
            tick();
        end
        go_idle(20);
    endtask

    initial begin
        test_reset();
        test_cout_stream();
        test_dout_stream();
        test_underflow();
        test_train_mid_frame();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
